// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multicycle main controller: state codes, opcodes,
// data-processing commands and datapath select values.
package ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t FETCH    = 4'd0;
    localparam state_t DECODE   = 4'd1;
    localparam state_t MEMADR   = 4'd2;
    localparam state_t MEMREAD  = 4'd3;
    localparam state_t MEMWB    = 4'd4;
    localparam state_t MEMWRITE = 4'd5;
    localparam state_t EXECUTER = 4'd6;
    localparam state_t EXECUTEI = 4'd7;
    localparam state_t ALUWB    = 4'd8;
    localparam state_t BRANCH   = 4'd9;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Controller bundle: instruction fields in, datapath selects and write requests out.
// master is the controller, slave is the datapath/condition-logic side.
interface mc_control_fsm_if;

    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       IRWrite;
    logic       NextPC;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [1:0] ALUControl;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic [3:0] State;

    modport master (
        input  Op, Funct, Rd,
        output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
               ALUControl, FlagW, PCS, RegW, MemW, State
    );

    modport slave (
        output Op, Funct, Rd,
        input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
               ALUControl, FlagW, PCS, RegW, MemW, State
    );

endinterface

// File: rtl/mc_control_fsm_alu_ctrl_dec.sv
// ALU decoder: maps the data-processing command and S bit to ALU control,
// flag-write requests and a register-write veto for compares/unsupported commands.
module alu_ctrl_dec
    import ctrl_pkg::*;
(
    input  logic       alu_op,
    input  logic [4:0] funct,
    output logic [1:0] alu_control,
    output logic [1:0] flag_w,
    output logic       no_write
);

    logic [1:0] ctl;
    logic       arith;
    logic       supported;
    logic       s_bit;

    // CMP is a flag-only SUB, so it forces S and never writes a register.
    always_comb begin
        ctl       = ALU_ADD;
        arith     = 1'b0;
        supported = 1'b1;
        s_bit     = funct[0];
        no_write  = 1'b0;
        case (funct[4:1])
            CMD_ADD: begin ctl = ALU_ADD; arith = 1'b1; end
            CMD_SUB: begin ctl = ALU_SUB; arith = 1'b1; end
            CMD_AND: ctl = ALU_AND;
            CMD_ORR: ctl = ALU_ORR;
            CMD_CMP: begin ctl = ALU_SUB; arith = 1'b1; s_bit = 1'b1; no_write = 1'b1; end
            default: begin supported = 1'b0; no_write = 1'b1; end
        endcase
        alu_control = alu_op ? ctl : ALU_ADD;
        flag_w      = (alu_op && supported) ? {s_bit, s_bit & arith} : 2'b00;
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle main controller: Moore FSM stepping fetch/decode/execute/writeback and
// issuing unconditional write requests that condition logic later gates with CondEx.
module mc_control_fsm
    import ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    mc_control_fsm_if.master   bus
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] next_state;
    logic               alu_op;
    logic [1:0]         alu_control;
    logic [1:0]         flag_w;
    logic               no_write;
    logic               irw_raw;
    logic               npc_raw;
    logic               regw_raw;
    logic               memw_raw;
    logic               branch_raw;

    alu_ctrl_dec u_alu_dec (
        .alu_op      (alu_op),
        .funct       (bus.Funct[4:0]),
        .alu_control (alu_control),
        .flag_w      (flag_w),
        .no_write    (no_write)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= FETCH;
        else
            state <= next_state;
    end

    // Next-state and Moore output decode; strobes are raw here and masked by reset below.
    always_comb begin
        next_state    = FETCH;
        alu_op        = 1'b0;
        irw_raw       = 1'b0;
        npc_raw       = 1'b0;
        regw_raw      = 1'b0;
        memw_raw      = 1'b0;
        branch_raw    = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = SRCB_REG;
        bus.ResultSrc = RES_ALUOUT;
        case (state)
            FETCH: begin
                irw_raw = 1'b1; npc_raw = 1'b1;
                bus.ALUSrcA = 1'b1; bus.ALUSrcB = SRCB_FOUR; bus.ResultSrc = RES_ALU;
                next_state = DECODE;
            end
            DECODE: begin
                bus.ALUSrcA = 1'b1; bus.ALUSrcB = SRCB_FOUR; bus.ResultSrc = RES_ALU;
                case (bus.Op)
                    OP_MEM:  next_state = MEMADR;
                    OP_DP:   next_state = bus.Funct[5] ? EXECUTEI : EXECUTER;
                    OP_BR:   next_state = BRANCH;
                    default: next_state = FETCH;
                endcase
            end
            MEMADR: begin
                bus.ALUSrcB = SRCB_IMM;
                next_state  = bus.Funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                bus.AdrSrc = 1'b1;
                next_state = MEMWB;
            end
            MEMWB: begin
                bus.ResultSrc = RES_RDATA; regw_raw = 1'b1;
            end
            MEMWRITE: begin
                bus.AdrSrc = 1'b1; memw_raw = 1'b1;
            end
            EXECUTER: begin
                alu_op = 1'b1; next_state = ALUWB;
            end
            EXECUTEI: begin
                alu_op = 1'b1; bus.ALUSrcB = SRCB_IMM; next_state = ALUWB;
            end
            ALUWB: begin
                regw_raw = ~no_write;
            end
            BRANCH: begin
                bus.ALUSrcB = SRCB_IMM; bus.ResultSrc = RES_ALU; branch_raw = 1'b1;
            end
            default: next_state = FETCH;
        endcase
    end

    assign bus.IRWrite    = irw_raw & ~reset;
    assign bus.NextPC     = npc_raw & ~reset;
    assign bus.RegW       = regw_raw & ~reset;
    assign bus.MemW       = memw_raw & ~reset;
    assign bus.PCS        = ~reset & (branch_raw | (regw_raw & (bus.Rd == 4'hF)));
    assign bus.FlagW      = reset ? 2'b00 : flag_w;
    assign bus.ALUControl = alu_control;
    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {bus.Op == OP_MEM, bus.Op == OP_BR};
    assign bus.State      = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench: per-instruction expected traces built from the instruction's
// class and fields, compared cycle by cycle against the controller outputs.
module tb_mc_control_fsm;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    logic [22:0] expQ[$];

    mc_control_fsm_if bus();

    mc_control_fsm #(.STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [22:0] mkWord(input int st, input bit irw, input bit npc,
                                           input bit adr, input bit asa, input logic [1:0] asb,
                                           input logic [1:0] rs, input logic [1:0] aluc,
                                           input logic [1:0] fw, input bit pcs, input bit rw,
                                           input bit mw, input logic [1:0] op);
        logic [1:0] regSrc;
        regSrc = {op == 2'b01, op == 2'b10};
        return {4'(st), irw, npc, adr, asa, asb, rs, op, regSrc, aluc, fw, pcs, rw, mw};
    endfunction

    // Expected per-cycle outputs for one whole instruction, from its class and fields.
    task automatic buildTrace(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
        bit         supported, arith, s, wr;
        logic [1:0] aluc, fw;
        expQ.delete();
        expQ.push_back(mkWord(0, 1, 1, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 0, op));
        expQ.push_back(mkWord(1, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 0, op));
        case (op)
            2'b01: begin
                expQ.push_back(mkWord(2, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, op));
                if (funct[0]) begin
                    expQ.push_back(mkWord(3, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, op));
                    expQ.push_back(mkWord(4, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, rd == 4'hF, 1, 0, op));
                end else begin
                    expQ.push_back(mkWord(5, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, op));
                end
            end
            2'b00: begin
                supported = 1; arith = 0; s = funct[0]; aluc = 2'b00;
                case (funct[4:1])
                    4'b0100: begin aluc = 2'b00; arith = 1; end
                    4'b0010: begin aluc = 2'b01; arith = 1; end
                    4'b0000: aluc = 2'b10;
                    4'b1100: aluc = 2'b11;
                    4'b1010: begin aluc = 2'b01; arith = 1; s = 1; end
                    default: supported = 0;
                endcase
                wr = supported && (funct[4:1] != 4'b1010);
                fw = supported ? {s, s & arith} : 2'b00;
                expQ.push_back(mkWord(funct[5] ? 7 : 6, 0, 0, 0, 0, funct[5] ? 2'b01 : 2'b00,
                                      2'b00, aluc, fw, 0, 0, 0, op));
                expQ.push_back(mkWord(8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00,
                                      wr && (rd == 4'hF), wr, 0, op));
            end
            2'b10: expQ.push_back(mkWord(9, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 1, 0, 0, op));
            default: ;
        endcase
    endtask

    task automatic checkOutput(input string tag, input logic [22:0] expected);
        logic [22:0] observed;
        observed = {bus.State, bus.IRWrite, bus.NextPC, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB,
                    bus.ResultSrc, bus.ImmSrc, bus.RegSrc, bus.ALUControl, bus.FlagW,
                    bus.PCS, bus.RegW, bus.MemW};
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Runs one instruction from FETCH; entered and left just after a rising edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [5:0] funct,
                                 input logic [3:0] rd, input string name);
        bus.Op = op; bus.Funct = funct; bus.Rd = rd;
        buildTrace(op, funct, rd);
        foreach (expQ[i]) begin
            #1;
            checkOutput($sformatf("%s[%0d]", name, i), expQ[i]);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [3:0] cmdTable[5];
        logic [3:0] cmd, rdR;
        logic [1:0] opR;
        cmdTable = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};

        reset = 1'b1; bus.Op = 2'b00; bus.Funct = 6'd0; bus.Rd = 4'd0;
        #1;
        checkOutput("reset", mkWord(0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 0, 2'b00));
        @(posedge clk);
        #1;
        checkOutput("reset_edge", mkWord(0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 0, 2'b00));
        #2 reset = 1'b0;

        applyStimulus(2'b01, 6'b011001, 4'd3,  "ldr");
        applyStimulus(2'b01, 6'b011000, 4'd5,  "str");
        applyStimulus(2'b00, 6'b001001, 4'd2,  "adds_reg");
        applyStimulus(2'b00, 6'b110101, 4'd0,  "cmp_imm");
        applyStimulus(2'b10, 6'b000000, 4'd0,  "branch");
        applyStimulus(2'b00, 6'b011000, 4'hF,  "orr_pc");
        applyStimulus(2'b11, 6'b101010, 4'd7,  "undef");
        applyStimulus(2'b01, 6'b000001, 4'hF,  "ldr_pc");

        for (int n = 0; n < 40; n++) begin
            opR = 2'($urandom_range(0, 3));
            rdR = 4'($urandom_range(0, 15));
            cmd = ($urandom_range(0, 3) != 0) ? cmdTable[$urandom_range(0, 4)]
                                              : 4'($urandom_range(0, 15));
            applyStimulus(opR, {1'($urandom_range(0, 1)), cmd, 1'($urandom_range(0, 1))},
                          rdR, $sformatf("rand%0d", n));
        end

        // Abort a store while in MEMWRITE, between clock edges.
        bus.Op = 2'b01; bus.Funct = 6'b000000; bus.Rd = 4'd1;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("memwrite", mkWord(5, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b01));
        #1 reset = 1'b1;
        #1;
        checkOutput("abort", mkWord(0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 0, 2'b01));
        #2 reset = 1'b0;
        #1;
        checkOutput("released", mkWord(0, 1, 1, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 0, 2'b01));
        @(posedge clk);
        #1;
        checkOutput("after_abort", mkWord(1, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 0, 2'b01));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
